// File: rtl/pito_pkg.sv
// Shared types and constants for the pito UART transmit path.
package pito_pkg;

    localparam logic [31:0] UART_ADDR_DEF = 32'h8000_0000;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/pito_sync_fifo.sv
// Single-clock FIFO with registered count/full/empty flags.
module pito_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST_FREE = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    count <= count + 1'b1;
                    empty <= 1'b0;
                    full  <= (count == LAST_FREE);
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                    empty <= (count == ONE);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/pito_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping pito data-memory stores.
module pito_uart_tx
    import pito_pkg::*;
#(
    parameter logic [31:0] UART_ADDR    = UART_ADDR_DEF,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          DROP_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmem_req,
    input  logic                  dmem_we,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_wdata,
    input  logic [3:0]            dmem_be,
    input  logic                  clr_i,
    output logic                  txd,
    output logic                  busy,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  irq
);

    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam int IW    = $clog2(UART_DATA_BITS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(UART_DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(UART_STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    uart_tx_state_e            state;
    logic [BW-1:0]             baud_cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic [CNT_W-1:0]          fifo_count;

    logic hit;
    logic push;
    logic pop;
    logic drop;
    logic baud_last;
    logic stop_done;
    logic unused_lanes;

    assign unused_lanes = ^{dmem_wdata[31:8], dmem_be[3:1]};

    assign hit = dmem_req && dmem_we
              && (dmem_addr == UART_ADDR) && dmem_be[0];

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign stop_done = baud_last && (bit_idx == STOP_LAST);

    // A frame boundary frees a slot in the same cycle a full FIFO is hit.
    assign pop  = !fifo_empty
               && ((state == IDLE) || ((state == STOP) && stop_done));
    assign push = hit && (!fifo_full || pop);
    assign drop = hit && fifo_full && !pop;

    assign irq = fifo_empty && !busy;

    pito_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (dmem_wdata[UART_DATA_BITS-1:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg    <= fifo_rdata;
                        baud_cnt <= '0;
                        state    <= START;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        txd      <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[UART_DATA_BITS-1:1]};
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= STOP;
                            txd     <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (stop_done) begin
                            bit_idx <= '0;
                            if (!fifo_empty) begin
                                shreg <= fifo_rdata;
                                state <= START;
                                txd   <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear restarts the tally at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_i) begin
                drop_cnt <= DROP_CNT_W'(1);
            end else if (drop_cnt != {DROP_CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (clr_i) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    a_count_range : assert property (
        @(posedge clk) disable iff (rst) fifo_count <= CNT_MAX
    );

endmodule

// File: doc/pito_uart_tx.md
Name: pito_uart_tx

Overview:
- Memory-mapped UART transmit stage that sits directly downstream of the pito core data-memory port.
- Snoops core store requests to the UART data address and buffers the accepted bytes in a small FIFO.
- Serializes bytes onto a TX pin as 8N1 frames, LSB first.
- Exposes status flags and a level interrupt to the core/SoC.

Parameters:
- UART_ADDR, 32'h8000_0000, byte address that selects a UART data store.
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of two, >=2.
- CLKS_PER_BIT, 434, clk cycles per serial bit; must be >=2.
- DROP_CNT_W, 8, width of the saturating dropped-byte counter.

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- dmem_req  in  1  core data-memory request valid.
- dmem_we  in  1  core data-memory write enable.
- dmem_addr  in  32  core data-memory byte address.
- dmem_wdata  in  32  core store data.
- dmem_be  in  4  core store byte enables.
- clr_i  in  1  one-cycle pulse; clears overflow and drop_cnt.
- txd  out  1  serial output; idle high.
- busy  out  1  frame in progress (state != IDLE).
- fifo_empty  out  1  FIFO holds no bytes.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- overflow  out  1  sticky: a store was dropped.
- drop_cnt  out  DROP_CNT_W  saturating count of dropped stores.
- irq  out  1  high when fifo_empty && !busy (all data sent).

Behaviour:
- Reset values: txd=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, drop_cnt=0, irq=1, state=IDLE, rd/wr pointers=0, baud counter=0, bit index=0.
- Store hit is `dmem_req && dmem_we && dmem_addr==UART_ADDR && dmem_be[0]`. Data is `dmem_wdata[7:0]`; other lanes are ignored. A store with `be[0]==0` is no hit.
- Push:
  - A hit is accepted if `!fifo_full`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow is set, and drop_cnt increments, saturating at all-ones.
- Count, full, and empty flags are registered and update on the edge after push/pop. Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- If clr_i coincides with a drop, the drop wins: overflow=1 and drop_cnt=1.
- FSM states:
  - IDLE:
    - If !fifo_empty, pop the head into the shift register, reset the baud counter, and go to START.
    - txd is registered, so txd=0 from the edge entering START.
  - START:
    - txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - txd = shreg[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
    - After index 7 completes, go to STOP.
  - STOP:
    - txd=1 for CLKS_PER_BIT cycles.
    - On completion, if !fifo_empty, pop and go directly to START (back-to-back frames, no idle gap). Else go to IDLE.
- Latency: store hit in cycle t → FIFO non-empty after edge t+1 → pop at edge t+2 → txd falls after edge t+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1. It never advances in IDLE.
- Reset mid-frame forces txd=1 immediately (async). The FIFO contents and the partial frame are discarded.

Decomposition:
- pito_pkg receives:
  - UART_ADDR default constant.
  - `uart_tx_state_e` enum (IDLE, START, DATA, STOP).
  - UART frame constants (8 data bits, 1 stop bit).
- Sub-module pito_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, async active-high reset. Reusable by a later RX stage.
- FSM, baud counter, and address decode stay in pito_uart_tx.

Test Plan:
- Single byte, CLKS_PER_BIT=4: store 32'h0000_0055 to 32'h8000_0000 with be=4'b0001 → txd falls 2 edges later. Line sequence is 0,1,0,1,0,1,0,1,0,1 with 4 cycles each. Then busy=0, irq=1.
- Byte-lane filter: store with be=4'b1110 to UART_ADDR, and a store with be=4'b0001 to 32'h8000_0004 → no push, fifo_empty stays 1, txd stays 1.
- Back-to-back: 3 stores of 8'hA1, 8'hB2, 8'hC3 in consecutive cycles → three frames with no idle gap; txd continuous for 120 cycles (CLKS_PER_BIT=4); decoded bytes in order.
- Overflow, FIFO_DEPTH=8: 11 consecutive stores while the first frame is still running → first byte popped, 8 buffered, fifo_full=1. Remaining 2 dropped, drop_cnt=2, overflow=1. Then clr_i → both cleared; 9 bytes are transmitted in total.
- Full with simultaneous pop: FIFO full and a store hit in the same cycle as a STOP→START pop → byte accepted, count stays 8, drop_cnt unchanged.
- Mid-frame reset: assert rst during the DATA state of byte 8'hFF → txd=1 the same cycle without waiting for a clock. After release: fifo_empty=1, state IDLE, no residual frame.
